ram512_burst_reader: RTL and testbench

Initiator-side companion to `ram512`: sequentially reads a burst of 1–512 words from a `ram512` instance and streams them out over a valid/ready interface.

- Holds `ram512` write-enable low and drives its address port, one word per cycle when downstream accepts.
- Used for memory dumps, screen-buffer scan-out and copy engines.

---
 rtl/ram512_burst_reader_pkg.sv | 21 ++
 rtl/ram512_burst_reader_if.sv | 29 ++
 rtl/ram512_burst_reader_burst_counter.sv | 37 +++
 rtl/ram512_burst_reader.sv | 86 ++++++++
 tb/tb_ram512_burst_reader.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/ram512_burst_reader_pkg.sv
// Shared constants, FSM encoding and the burst-length saturation helper
// for the ram512 burst reader.
package ram512_burst_reader_pkg;

    localparam int ADDR_W    = 9;    // ram512 address width, fixed
    localparam int DATA_W    = 16;   // word width
    localparam int CNT_W     = 10;   // width of the requested word count
    localparam int RAM_WORDS = 512;  // words in one ram512

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Requests beyond the RAM size collapse to one full pass over the RAM.
    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
        return (c > CNT_W'(RAM_WORDS)) ? CNT_W'(RAM_WORDS) : c;
    endfunction

endpackage

// File: rtl/ram512_burst_reader_if.sv
// Command, ram512 port and output stream signals of the burst reader.
// The slave modport is the reader itself; the master modport is whatever
// issues commands, provides the RAM read data and consumes the stream.
interface ram512_burst_reader_if;
    import ram512_burst_reader_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_load;
    logic [DATA_W-1:0] ram_out;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    modport master (
        output start, base_addr, count, ram_out, out_ready,
        input  ram_address, ram_load, out_data, out_valid, busy, done
    );

    modport slave (
        input  start, base_addr, count, ram_out, out_ready,
        output ram_address, ram_load, out_data, out_valid, busy, done
    );

endinterface

// File: rtl/ram512_burst_reader_burst_counter.sv
// Burst bookkeeping: a wrapping 9-bit read address and a 10-bit count of
// words still to be fetched from the RAM.
module burst_counter
    import ram512_burst_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  count,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              zero
);

    logic [CNT_W-1:0] remain_r;

    // Load a new burst, or advance one word; the address wraps 511 -> 0 by
    // plain 9-bit overflow.
    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            remain_r <= '0;
        end else if (load) begin
            addr     <= base;
            remain_r <= sat_count(count);
        end else if (step) begin
            addr     <= addr + 1'b1;
            remain_r <= remain_r - 1'b1;
        end
    end

    assign zero = (remain_r == '0);

endmodule

// File: rtl/ram512_burst_reader.sv
// Reads a burst of 1..512 consecutive words from a ram512 (wrapping at the
// top of memory) and streams them out over a registered valid/ready port.
module ram512_burst_reader
    import ram512_burst_reader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    ram512_burst_reader_if.slave   bus
);

    state_t            state;
    logic [ADDR_W-1:0] addr_r;
    logic              zero;
    logic              load;
    logic              ld;
    logic [DATA_W-1:0] out_data_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              done_r;

    // A zero-length command is dropped right here, so it never leaves IDLE.
    assign load = (state == IDLE) && bus.start && (bus.count != '0);

    // Fetch the next word whenever the output register is empty or being
    // drained this cycle and words remain.
    assign ld = (state == STREAM) && (!out_valid_r || bus.out_ready) && !zero;

    burst_counter u_burst_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .base  (bus.base_addr),
        .count (bus.count),
        .step  (ld),
        .addr  (addr_r),
        .zero  (zero)
    );

    // The reader never writes the RAM.
    assign bus.ram_load    = 1'b0;
    assign bus.ram_address = addr_r;

    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

    // Burst FSM with the output register; busy and done are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (load) begin
                        busy_r <= 1'b1;
                        state  <= STREAM;
                    end
                end
                STREAM: begin
                    if (ld) begin
                        out_data_r  <= bus.ram_out;
                        out_valid_r <= 1'b1;
                    end else if (out_valid_r && bus.out_ready && zero) begin
                        // Last word taken: close the burst.
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram512_burst_reader.sv
// Directed bench for ram512_burst_reader with a combinational ram512 model.
module tb_ram512_burst_reader;
    import ram512_burst_reader_pkg::*;

    logic clk;
    logic rst_n;

    ram512_burst_reader_if bus ();

    ram512_burst_reader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] mem [512];
    assign bus.ram_out = mem[bus.ram_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] beats[$];
    logic [8:0]  addrs[$];
    int          rdy_pat[$];
    int          first_v;
    int          mid_start_at = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [8:0] base, input logic [9:0] cnt);
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.count     = cnt;
        tick();
        bus.start = 1'b0;
    endtask

    // Runs from the negedge after the accepting edge until done (or budget),
    // collecting accepted beats and checking hold, busy, done timing, ram_load.
    task automatic stream(input int budget);
        int          last_acc;
        bit          seen_done;
        logic        pv, pr;
        logic [15:0] pd;
        beats.delete();
        addrs.delete();
        last_acc  = -10;
        seen_done = 1'b0;
        first_v   = -1;
        pv = 1'b0; pr = 1'b1; pd = '0;
        for (int i = 0; i < budget && !seen_done; i++) begin
            bus.out_ready = (rdy_pat.size() != 0) ? (rdy_pat.pop_front() != 0) : 1'b1;
            if (i == mid_start_at) begin
                bus.start     = 1'b1;
                bus.base_addr = 9'd300;
                bus.count     = 10'd2;
            end else begin
                bus.start = 1'b0;
            end
            addrs.push_back(bus.ram_address);
            if (bus.done) begin
                seen_done = 1'b1;
                check("done_after_last", i, last_acc + 1);
                check("busy_at_done", bus.busy, 0);
                check("valid_at_done", bus.out_valid, 0);
            end else begin
                check("busy_in_burst", bus.busy, 1);
                if (pv && !pr) begin
                    check("hold_valid", bus.out_valid, 1);
                    check("hold_data", bus.out_data, pd);
                end
                if (bus.out_valid && first_v < 0) first_v = i;
                if (bus.out_valid && bus.out_ready) begin
                    beats.push_back(bus.out_data);
                    last_acc = i;
                end
            end
            check("ram_load", bus.ram_load, 0);
            pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data;
            tick();
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        mid_start_at  = -1;
        check("done_seen", seen_done, 1);
    endtask

    initial begin
        int errs;
        for (int i = 0; i < 512; i++) mem[i] = 16'hC000 | 16'(i);
        mem[5]   = 16'h00A5;
        mem[510] = 16'h1111;
        mem[511] = 16'h2222;
        mem[0]   = 16'h3333;
        mem[1]   = 16'h4444;
        mem[100] = 16'h1234;
        mem[101] = 16'h5678;

        bus.start = 1'b0; bus.base_addr = '0; bus.count = '0; bus.out_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_addr", bus.ram_address, 0);
        check("rst_load", bus.ram_load, 0);
        rst_n = 1'b1;
        tick();

        // Single word
        issue(9'd5, 10'd1);
        stream(20);
        check("single_beats", beats.size(), 1);
        if (beats.size() >= 1) check("single_data", beats[0], 16'h00A5);
        check("single_latency", first_v, 1);

        // Wrap across the top of memory
        issue(9'd510, 10'd4);
        stream(20);
        check("wrap_beats", beats.size(), 4);
        if (beats.size() == 4) begin
            check("wrap_d0", beats[0], 16'h1111);
            check("wrap_d1", beats[1], 16'h2222);
            check("wrap_d2", beats[2], 16'h3333);
            check("wrap_d3", beats[3], 16'h4444);
        end
        if (addrs.size() >= 4) begin
            check("wrap_a0", addrs[0], 510);
            check("wrap_a1", addrs[1], 511);
            check("wrap_a2", addrs[2], 0);
            check("wrap_a3", addrs[3], 1);
        end

        // Backpressure
        rdy_pat = '{1, 0, 0, 1, 1};
        issue(9'd0, 10'd3);
        stream(20);
        check("bp_beats", beats.size(), 3);
        if (beats.size() == 3) begin
            check("bp_d0", beats[0], 16'h3333);
            check("bp_d1", beats[1], 16'h4444);
            check("bp_d2", beats[2], 16'hC002);
        end

        // Zero count is a no-op
        issue(9'd7, 10'd0);
        check("zero_busy", bus.busy, 0);
        check("zero_valid", bus.out_valid, 0);
        tick();
        check("zero_done", bus.done, 0);
        check("zero_busy2", bus.busy, 0);

        // Oversized count saturates to 512
        issue(9'd0, 10'd700);
        stream(600);
        check("sat_beats", beats.size(), 512);
        errs = 0;
        if (beats.size() == 512)
            for (int i = 0; i < 512; i++) if (beats[i] !== mem[i]) errs++;
        check("sat_data_errs", errs, 0);

        // Start during a burst is ignored
        mid_start_at = 2;
        issue(9'd20, 10'd5);
        stream(30);
        check("ign_beats", beats.size(), 5);
        errs = 0;
        if (beats.size() == 5)
            for (int i = 0; i < 5; i++) if (beats[i] !== (16'hC014 + 16'(i))) errs++;
        check("ign_data_errs", errs, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ign_no_second_busy", bus.busy, 0);
            check("ign_no_second_valid", bus.out_valid, 0);
        end

        // Reset during beat 2 of 8
        issue(9'd40, 10'd8);
        tick();
        tick();
        check("abort_beat2_valid", bus.out_valid, 1);
        check("abort_beat2_data", bus.out_data, 16'hC029);
        rst_n = 1'b0;
        #1;
        check("abort_valid", bus.out_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_load", bus.ram_load, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_abort_valid", bus.out_valid, 0);
        check("post_abort_done", bus.done, 0);
        issue(9'd100, 10'd2);
        stream(20);
        check("restart_beats", beats.size(), 2);
        if (beats.size() == 2) begin
            check("restart_d0", beats[0], 16'h1234);
            check("restart_d1", beats[1], 16'h5678);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
